// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle control FSM -- state codes,
// LEGv8 opcode constants, ALU/PC select codes and a small state helper.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StErr    = 4'd10
  } state_e;

  // Full 11-bit opcodes
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpSub  = 11'b11001011000;
  localparam logic [10:0] OpAnd  = 11'b10001010000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;
  // Prefix-only opcodes: CBZ matches bits [10:3], B matches bits [10:5]
  localparam logic [7:0]  OpCbzHi = 8'b10110100;
  localparam logic [5:0]  OpBHi   = 6'b000101;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpPassB = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  localparam logic [1:0] SrcBReg    = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBOffset = 2'b10;
  localparam logic [1:0] SrcBBrOff  = 2'b11;

  // States that sit on the shared memory and may stall on mem_ready
  function automatic logic waits_on_mem(state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: shared-memory handshake between the control FSM (master) and
// the memory (slave).
interface mc_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output i_or_d,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  i_or_d,
    output mem_ready
  );
endinterface

// File: rtl/mc_ctrl_opdec.sv
// mc_ctrl_opdec: purely combinational opcode classifier for the control FSM.
module mc_ctrl_opdec
  import mc_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output logic        is_ldur,
  output logic        is_stur,
  output logic        is_rtype,
  output logic        is_cbz,
  output logic        is_b,
  output logic        illegal
);

  // Classes are mutually exclusive; anything unmatched is illegal
  always_comb begin
    is_ldur  = (opcode == OpLdur);
    is_stur  = (opcode == OpStur);
    is_rtype = (opcode == OpAdd) || (opcode == OpSub) ||
               (opcode == OpAnd) || (opcode == OpOrr);
    is_cbz   = (opcode[10:3] == OpCbzHi);
    is_b     = (opcode[10:5] == OpBHi);
    illegal  = !(is_ldur || is_stur || is_rtype || is_cbz || is_b);
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle LEGv8 control FSM for a shared instruction/data memory.
// Define MC_CTRL_PERF_EN to build the retired-instruction counter; otherwise
// instr_cnt is tied to zero.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  mc_ctrl_if.master   mem,
  input  logic [10:0] opcode,
  input  logic        zero,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        reg2loc,
  output logic [3:0]  state,
  output logic        err,
  output logic [31:0] instr_cnt
);

  localparam logic [7:0] WaitMax = 8'(WAIT_MAX);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       is_ldur, is_stur, is_rtype, is_cbz, is_b, illegal;
  logic       mem_req, mem_we, i_or_d;
  // zero gates the PC in the datapath together with pc_write_cond
  logic       unused_zero;

  assign unused_zero = zero;

  mc_ctrl_opdec u_opdec (
    .opcode   (opcode),
    .is_ldur  (is_ldur),
    .is_stur  (is_stur),
    .is_rtype (is_rtype),
    .is_cbz   (is_cbz),
    .is_b     (is_b),
    .illegal  (illegal)
  );

  // Next state and consecutive memory-wait counter
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (mem.mem_ready) state_d = StDecode;
      StDecode: begin
        if (illegal)                 state_d = StErr;
        else if (is_ldur || is_stur) state_d = StMemAdr;
        else if (is_rtype)           state_d = StExec;
        else if (is_cbz)             state_d = StBranch;
        else if (is_b)               state_d = StJump;
        else                         state_d = StErr;
      end
      StMemAdr: begin
        if (is_ldur)      state_d = StMemRd;
        else if (is_stur) state_d = StMemWr;
        else              state_d = StErr;
      end
      StMemRd:  if (mem.mem_ready) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (mem.mem_ready) state_d = StFetch;
      StExec:   state_d = StRwb;
      StRwb:    state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      StErr:    state_d = StErr;
      default:  state_d = StErr;
    endcase

    // Counter clears on ready or exit; the WAIT_MAX-th stalled cycle escapes to ERR
    wait_d = '0;
    if (waits_on_mem(state_q) && !mem.mem_ready) begin
      if (wait_q + 8'd1 >= WaitMax) state_d = StErr;
      else                          wait_d  = wait_q + 8'd1;
    end
  end

  // State and wait-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Moore decode of datapath controls; IR/PC load in FETCH qualified by mem_ready
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SrcBReg;
    alu_op        = AluOpAdd;
    pc_src        = PcSrcAlu;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg2loc       = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = SrcBFour;
        ir_write  = mem.mem_ready;
        pc_write  = mem.mem_ready;
      end
      StDecode: alu_src_b = SrcBBrOff;
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBOffset;
        reg2loc   = 1'b1;
      end
      StMemRd: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        reg2loc = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = AluOpFunct;
      end
      StRwb: reg_write = 1'b1;
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = AluOpPassB;
        pc_write_cond = 1'b1;
        pc_src        = PcSrcAluOut;
        reg2loc       = 1'b1;
      end
      StJump: begin
        pc_write = 1'b1;
        pc_src   = PcSrcJump;
      end
      default: ;
    endcase
    // Reset drops every enable immediately, without waiting for a clock
    if (!rst_n) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_write     = 1'b0;
    end
  end

  assign mem.mem_req = mem_req;
  assign mem.mem_we  = mem_we;
  assign mem.i_or_d  = i_or_d;
  assign state       = state_q;
  assign err         = (state_q == StErr);

`ifdef MC_CTRL_PERF_EN
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic        retire;

  // An instruction retires when its last state hands back to FETCH
  always_comb begin
    retire = (state_d == StFetch) &&
             (state_q inside {StMemWb, StMemWr, StRwb, StBranch, StJump});
    instr_cnt_d = retire ? instr_cnt_q + 32'd1 : instr_cnt_q;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instr_cnt_q <= '0;
    else        instr_cnt_q <= instr_cnt_d;
  end

  assign instr_cnt = instr_cnt_q;
`else
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized instruction-level stimulus for mc_ctrl; expected
// per-cycle control behaviour is queued by the stimulus and checked by a
// separate negedge monitor.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  localparam int unsigned WaitMax = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] opcode = '0;
  logic        zero = 1'b0;
  logic        ir_write, pc_write, pc_write_cond, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic        reg_write, mem_to_reg, reg2loc, err;
  logic [3:0]  state;
  logic [31:0] instr_cnt;

  mc_ctrl_if mem_bus ();

  mc_ctrl #(.WAIT_MAX(WaitMax)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem           (mem_bus.master),
    .opcode        (opcode),
    .zero          (zero),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_src        (pc_src),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .reg2loc       (reg2loc),
    .state         (state),
    .err           (err),
    .instr_cnt     (instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic        req, we, iod, irw, pcw, pcwc, rw, m2r, r2l, err;
    logic [1:0]  pcsrc;
    logic        pcsrc_chk;
    logic [31:0] icnt;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          step_no = 0;
  logic [31:0] model_cnt = '0;

  // Monitor: one expected record per cycle, compared away from the clock edge
  exp_t       m_e;
  logic [9:0] m_got, m_want;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e    = exp_q.pop_front();
      m_got  = {mem_bus.mem_req, mem_bus.mem_we, mem_bus.i_or_d, ir_write, pc_write,
                pc_write_cond, reg_write, mem_to_reg, reg2loc, err};
      m_want = {m_e.req, m_e.we, m_e.iod, m_e.irw, m_e.pcw, m_e.pcwc, m_e.rw, m_e.m2r,
                m_e.r2l, m_e.err};
      checks++;
      if (state !== m_e.st || m_got !== m_want || instr_cnt !== m_e.icnt ||
          (m_e.pcsrc_chk && pc_src !== m_e.pcsrc)) begin
        errors++;
        $display("FAIL ctl step=%0d got st=%0d flags=%b pc_src=%b cnt=%0d exp st=%0d flags=%b pc_src=%b cnt=%0d",
                 step_no, state, m_got, pc_src, instr_cnt, m_e.st, m_want, m_e.pcsrc, m_e.icnt);
      end
      step_no++;
    end
  end

  function automatic exp_t rec(input state_e s);
    exp_t e;
    e      = '0;
    e.st   = s;
    e.icnt = model_cnt;
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [10:0] ropc();
    return 11'($urandom);
  endfunction

  // 0 LDUR, 1 STUR, 2 R-type, 3 CBZ, 4 B, 5 illegal
  function automatic int classify(input logic [10:0] o);
    if (o == 11'b11111000010) return 0;
    if (o == 11'b11111000000) return 1;
    if (o == 11'b10001011000 || o == 11'b11001011000 ||
        o == 11'b10001010000 || o == 11'b10101010000) return 2;
    if (o ==? 11'b10110100???) return 3;
    if (o ==? 11'b000101?????) return 4;
    return 5;
  endfunction

  function automatic logic [10:0] rand_opcode();
    int          k;
    logic [10:0] o;
    k = $urandom_range(0, 19);
    if (k < 3)       o = 11'b11111000010;
    else if (k < 6)  o = 11'b11111000000;
    else if (k < 11) begin
      case ($urandom_range(0, 3))
        0:       o = 11'b10001011000;
        1:       o = 11'b11001011000;
        2:       o = 11'b10001010000;
        default: o = 11'b10101010000;
      endcase
    end
    else if (k < 14) o = {8'b10110100, 3'($urandom)};
    else if (k < 17) o = {6'b000101, 5'($urandom)};
    else begin
      o = ropc();
      while (classify(o) != 5) o = ropc();
    end
    return o;
  endfunction

  task automatic step(input logic r, input logic [10:0] opc, input logic rdy, input logic z,
                      input exp_t e);
    @(posedge clk);
    #1;
    rst_n             = r;
    opcode            = opc;
    mem_bus.mem_ready = rdy;
    zero              = z;
    exp_q.push_back(e);
  endtask

  task automatic retire();
`ifdef MC_CTRL_PERF_EN
    model_cnt = model_cnt + 32'd1;
`endif
  endtask

  task automatic reset_pulse(input int n);
    exp_t e;
    model_cnt = '0;
    for (int i = 0; i < n; i++) begin
      e = rec(StFetch);
      step(1'b0, ropc(), rb(), rb(), e);
    end
  endtask

  task automatic err_tail(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e     = rec(StErr);
      e.err = 1'b1;
      step(1'b1, ropc(), rb(), rb(), e);
    end
    reset_pulse(1);
  endtask

  // Memory-phase stall cycles; returns 1 when the stall runs into the timeout
  task automatic mem_wait(input state_e s, input int n, input logic [10:0] opc,
                          output logic timed_out);
    exp_t e;
    for (int i = 0; i < n && i < WaitMax; i++) begin
      e     = rec(s);
      e.req = 1'b1;
      e.iod = 1'b1;
      e.we  = (s == StMemWr);
      e.r2l = (s == StMemWr);
      step(1'b1, opc, 1'b0, rb(), e);
    end
    timed_out = (n >= WaitMax);
  endtask

  // One instruction: fetch stalls fw, memory stalls mw, zero flag z
  task automatic run_instr(input logic [10:0] opc, input int fw, input int mw, input logic z,
                           input logic abort, input int tail);
    exp_t e;
    logic to;
    int   kind;
    kind = classify(opc);
    for (int i = 0; i < fw && i < WaitMax; i++) begin
      e     = rec(StFetch);
      e.req = 1'b1;
      step(1'b1, ropc(), 1'b0, rb(), e);
    end
    if (fw >= WaitMax) begin
      err_tail(tail);
      return;
    end
    e     = rec(StFetch);
    e.req = 1'b1;
    e.irw = 1'b1;
    e.pcw = 1'b1;
    step(1'b1, ropc(), 1'b1, rb(), e);
    e = rec(StDecode);
    step(1'b1, opc, rb(), rb(), e);
    case (kind)
      0, 1: begin
        e     = rec(StMemAdr);
        e.r2l = 1'b1;
        step(1'b1, opc, rb(), rb(), e);
        if (kind == 1 && abort) begin
          mem_wait(StMemWr, 1, opc, to);
          reset_pulse(2);
          return;
        end
        mem_wait(kind == 0 ? StMemRd : StMemWr, mw, opc, to);
        if (to) begin
          err_tail(tail);
          return;
        end
        e     = rec(kind == 0 ? StMemRd : StMemWr);
        e.req = 1'b1;
        e.iod = 1'b1;
        e.we  = (kind == 1);
        e.r2l = (kind == 1);
        step(1'b1, opc, 1'b1, rb(), e);
        if (kind == 0) begin
          e     = rec(StMemWb);
          e.rw  = 1'b1;
          e.m2r = 1'b1;
          step(1'b1, opc, rb(), rb(), e);
        end
        retire();
      end
      2: begin
        e = rec(StExec);
        step(1'b1, opc, rb(), rb(), e);
        e    = rec(StRwb);
        e.rw = 1'b1;
        step(1'b1, opc, rb(), rb(), e);
        retire();
      end
      3: begin
        e           = rec(StBranch);
        e.pcwc      = 1'b1;
        e.r2l       = 1'b1;
        e.pcsrc     = 2'b01;
        e.pcsrc_chk = 1'b1;
        step(1'b1, opc, rb(), z, e);
        retire();
      end
      4: begin
        e           = rec(StJump);
        e.pcw       = 1'b1;
        e.pcsrc     = 2'b10;
        e.pcsrc_chk = 1'b1;
        step(1'b1, opc, rb(), rb(), e);
        retire();
      end
      default: err_tail(tail);
    endcase
  endtask

  initial begin
    mem_bus.mem_ready = 1'b0;
    #1 rst_n = 1'b0;
    reset_pulse(2);
    // Directed scenarios
    run_instr(11'b10001011000, 0, 0, 1'b0, 1'b0, 4);   // ADD, immediate fetch
    run_instr(11'b11111000010, 1, 3, 1'b0, 1'b0, 4);   // LDUR, 3 read stalls
    run_instr(11'b10110100101, 0, 0, 1'b0, 1'b0, 4);   // CBZ zero=0
    run_instr(11'b10110100011, 2, 0, 1'b1, 1'b0, 4);   // CBZ zero=1
    run_instr(11'b11111000000, 0, 2, 1'b0, 1'b0, 4);   // STUR
    run_instr(11'b00010111111, 0, 0, 1'b0, 1'b0, 4);   // B
    run_instr(11'b11001011000, 3, 0, 1'b0, 1'b0, 4);   // SUB, max legal fetch stall
    run_instr(11'b11111111111, 0, 0, 1'b0, 1'b0, 100); // illegal, ERR held 100 cycles
    run_instr(11'b10001010000, 4, 0, 1'b0, 1'b0, 3);   // fetch timeout
    run_instr(11'b11111000010, 0, 4, 1'b0, 1'b0, 3);   // MEMRD timeout
    run_instr(11'b11111000000, 0, 4, 1'b0, 1'b0, 3);   // MEMWR timeout
    run_instr(11'b10101010000, 0, 0, 1'b0, 1'b0, 4);   // ORR
    run_instr(11'b11111000000, 1, 0, 1'b0, 1'b1, 4);   // STUR aborted by reset
    run_instr(11'b10001011000, 0, 0, 1'b0, 1'b0, 4);   // ADD right after reset
    // Randomized instruction stream
    for (int n = 0; n < 120; n++) begin
      run_instr(rand_opcode(),
                ($urandom_range(0, 29) == 0) ? 4 : int'($urandom_range(0, 3)),
                ($urandom_range(0, 29) == 0) ? 4 : int'($urandom_range(0, 3)),
                rb(), ($urandom_range(0, 19) == 0), int'($urandom_range(1, 6)));
    end
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending records, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
